// File: rtl/instruction_sequencer.sv
// Sequencer with IDLE/RUN/HALT control. It decodes one instruction per cycle and updates the program counter.
// Define INSTR_COUNT_EN to build the saturating retired-instruction counter; otherwise InstrCount is tied to zero.
module instruction_sequencer #(
    parameter logic [7:0]  START_ADDR = 8'd0,
    parameter logic [15:0] HALT_WORD  = 16'h00FF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] IR,
    input  logic        Zero,
    input  logic        Negative,
    input  logic [7:0]  RegA,
    output logic [7:0]  Address,
    output logic [2:0]  DA,
    output logic [2:0]  AA,
    output logic [2:0]  BA,
    output logic [4:0]  FS,
    output logic        MB,
    output logic        MD,
    output logic        RW,
    output logic        MW,
    output logic        Running,
    output logic        Halted,
    output logic [15:0] InstrCount,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [6:0]  op;
    logic        is_halt;
    logic        active;
    logic [7:0]  offset;
    logic [7:0]  next_addr;

    assign dbg_state = state;

    // Decode is purely combinational from IR, gated so nothing strobes outside an executing RUN cycle.
    always_comb begin
        op        = IR[15:9];
        is_halt   = (IR == HALT_WORD);
        active    = (state == RUN) && !is_halt && !Reset;
        offset    = {{2{IR[8]}}, IR[8:6], IR[2:0]};
        next_addr = Address + 8'd1;
        DA        = 3'd0;
        AA        = 3'd0;
        BA        = 3'd0;
        FS        = 5'd0;
        MB        = 1'b0;
        MD        = 1'b0;
        RW        = 1'b0;
        MW        = 1'b0;

        if (op[6:5] == 2'b11) begin
            if (op[4])
                next_addr = RegA;
            else if (op[0] ? Negative : Zero)
                next_addr = Address + offset;
        end

        if (active) begin
            DA = IR[8:6];
            AA = IR[5:3];
            BA = IR[2:0];
            case (op[6:5])
                2'b11: FS = 5'd0;
                2'b10: begin
                    FS = op[4:0];
                    MB = 1'b1;
                    RW = 1'b1;
                end
                default: begin
                    FS = op[4:0];
                    MD = op[4];
                    MW = op[5];
                    RW = ~op[5];
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            Address <= START_ADDR;
            Running <= 1'b0;
            Halted  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= RUN;
                        Address <= START_ADDR;
                        Running <= 1'b1;
                    end
                end
                RUN: begin
                    if (is_halt) begin
                        state   <= HALT;
                        Running <= 1'b0;
                        Halted  <= 1'b1;
                    end else begin
                        Address <= next_addr;
                    end
                end
                HALT: ;
                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Halted  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset)
            InstrCount <= 16'h0000;
        else if ((state == RUN) && !is_halt && (InstrCount != 16'hFFFF))
            InstrCount <= InstrCount + 16'd1;
    end
`else
    assign InstrCount = 16'h0000;
`endif

endmodule
